i2s_adc_receiver: RTL and testbench
===================================

I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 24, giving the sample width in bits, legal range 8..32.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock (12 MHz codec master clock domain).
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: receive enable.
REQ-005 The block SHALL have port bclk, input, 1 bit: I2S bit clock, asynchronous to clk.
REQ-006 The block SHALL have port adclrck, input, 1 bit: I2S word select; 0 selects left, 1 selects right.
REQ-007 The block SHALL have port adcdat, input, 1 bit: I2S serial ADC data, MSB first.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts the current frame.
REQ-009 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 The block SHALL have port left_data, output, DATA_W bits: left sample of the last frame.
REQ-011 The block SHALL have port right_data, output, DATA_W bits: right sample of the last frame.
REQ-012 The block SHALL have port out_valid, output, 1 bit: left_data and right_data hold an unaccepted frame.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag, a completed frame was dropped.
REQ-014 The block SHALL have port short_err, output, 1 bit: sticky flag, a channel slot ended before DATA_W bits.

Function
REQ-015 bclk, adclrck and adcdat SHALL each pass through a 2-flop synchronizer; a bclk rising edge ("edge") SHALL be detected from a third registered copy of synced bclk.
REQ-016 Operating constraint: bclk high time and low time SHALL each be at least 2 clk periods; behaviour outside this constraint is undefined.
REQ-017 At each edge, synced adclrck SHALL be compared with its value at the previous edge; a difference is a "ws change", and the bit sampled at that edge is the I2S one-bit delay slot and SHALL be discarded.
REQ-018 The FSM SHALL have states WAIT, SHIFT and DONE.
REQ-019 WAIT: at an edge with ws change to 0 (new left slot), go to SHIFT with bitcnt=0 and chan=left; all other edges are ignored.
REQ-020 SHIFT, edge without ws change: shift adcdat into the LSB of shreg and increment bitcnt; when bitcnt reaches DATA_W, latch shreg into the chan holding register and go to DONE.
REQ-021 DONE: further bits in the slot SHALL be ignored; at a ws change, set chan from the new adclrck, set bitcnt=0 and go to SHIFT.
REQ-022 SHIFT with ws change while bitcnt<DATA_W: discard the partial word, set short_err, start the new slot as in REQ-021, and mark the left word of the current frame invalid.
REQ-023 Frame complete = right word latched while a valid left word was latched earlier in the same frame; a right word without a valid left word SHALL be discarded.
REQ-024 On frame complete: if out_valid=0 or out_ready=1 in the same cycle, load left_data and right_data together and set out_valid=1; otherwise keep the outputs, set overrun, and drop the frame.
REQ-025 out_valid SHALL clear on out_valid & out_ready, unless a load occurs in the same cycle, in which case it stays 1.
REQ-026 Latency: taking the first clk edge that samples bclk=1 for the right-channel LSB as edge 0, out_valid=1 and the new data SHALL be visible after clk edge 3.
REQ-027 en=0 SHALL force WAIT and clear bitcnt, shreg and the left-valid mark; outputs, out_valid and the flags SHALL be held.
REQ-028 On en rising, reception SHALL resume only from the next left-slot start.
REQ-029 clr_err=1 SHALL clear overrun and short_err; if a set event occurs in the same cycle, set SHALL win.
REQ-030 left_data and right_data SHALL change only on a load, so they are stable while out_valid=1.

Reset
REQ-031 reset_n=0 SHALL asynchronously set the FSM to WAIT and clear bitcnt, shreg, the holding registers, left_data, right_data, out_valid, overrun, short_err and all synchronizer flops.
REQ-032 Reset asserted mid-slot SHALL discard the partial frame; after release, the first frame SHALL start at the next left-slot start.

Verification
REQ-033 Scenario, nominal frame: bclk = clk/8, DATA_W=24, 32-bit slots, left=0xA5A5A5, right=0x3C3C3C, out_ready=1 -> one out_valid pulse with exactly those values, at the latency of REQ-026.
REQ-034 Scenario, backpressure: out_ready=0 for 2 frames (L=0x000001/R=0x000002, then 0x000003/0x000004) -> out_valid=1 holding 0x000001/0x000002, overrun=1; clr_err then clears overrun.
REQ-035 Scenario, short slot: adclrck toggles after 16 bits of the left slot -> short_err=1, no out_valid for that frame, next full frame received correctly.
REQ-036 Scenario, mid-frame start: reset released mid right slot -> first output is the next complete frame and no partial data appears.
REQ-037 Scenario, en and reset mid-operation: en=0 mid left slot then en=1 -> no output until a full new frame; asserting reset_n=0 mid-frame clears all outputs to 0 immediately.
REQ-038 Scenario, simultaneous events: out_ready=1 in the same cycle as frame complete while out_valid=1 -> new data loaded, out_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// rtl/i2s_adc_receiver.sv - I2S ADC slave receiver delivering left/right sample pairs
module i2s_adc_receiver #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              bclk,
  input  logic              adclrck,
  input  logic              adcdat,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  output logic              overrun,
  output logic              short_err
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT, SHIFT, DONE} state_t;
  state_t state;

  logic [2:0]        bclk_sync;
  logic [1:0]        ws_sync;
  logic [1:0]        dat_sync;
  logic              ws_prev;
  logic              chan;
  logic              left_ok;
  logic              frame_pend;
  logic [CNT_W-1:0]  bitcnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] left_hold;
  logic [DATA_W-1:0] right_hold;
  logic [DATA_W-1:0] shreg_next;

  logic bclk_rise, ws, dat, ws_change, load, ovr_evt, short_evt;

  assign bclk_rise  = bclk_sync[1] & ~bclk_sync[2];
  assign ws         = ws_sync[1];
  assign dat        = dat_sync[1];
  assign ws_change  = bclk_rise & (ws != ws_prev);
  assign shreg_next = {shreg[DATA_W-2:0], dat};
  assign load       = frame_pend & (~out_valid | out_ready);
  assign ovr_evt    = frame_pend & ~load;
  assign short_evt  = en & ws_change & (state == SHIFT);

  // bclk_sync[2] is the extra delayed copy used only for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      dat_sync  <= '0;
      ws_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], bclk};
      ws_sync   <= {ws_sync[0], adclrck};
      dat_sync  <= {dat_sync[0], adcdat};
      if (bclk_rise)
        ws_prev <= ws;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT;
      bitcnt     <= '0;
      shreg      <= '0;
      chan       <= 1'b0;
      left_ok    <= 1'b0;
      frame_pend <= 1'b0;
      left_hold  <= '0;
      right_hold <= '0;
    end else begin
      frame_pend <= 1'b0;
      if (!en) begin
        state   <= WAIT;
        bitcnt  <= '0;
        shreg   <= '0;
        left_ok <= 1'b0;
      end else if (bclk_rise) begin
        if (ws_change) begin
          // The bit under a word-select change is the one-bit delay slot
          if (state != WAIT || !ws) begin
            state  <= SHIFT;
            chan   <= ws;
            bitcnt <= '0;
            shreg  <= '0;
            if (!ws || state == SHIFT)
              left_ok <= 1'b0;
          end
        end else if (state == SHIFT) begin
          shreg  <= shreg_next;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) begin
            state <= DONE;
            if (!chan) begin
              left_hold <= shreg_next;
              left_ok   <= 1'b1;
            end else begin
              right_hold <= shreg_next;
              frame_pend <= left_ok;
              left_ok    <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Set events take priority over clr_err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      if (load) begin
        left_data  <= left_hold;
        right_data <= right_hold;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_evt)
        overrun <= 1'b1;
      else if (clr_err)
        overrun <= 1'b0;
      if (short_evt)
        short_err <= 1'b1;
      else if (clr_err)
        short_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb/tb_i2s_adc_receiver.sv - directed bench for i2s_adc_receiver
`timescale 1ns/1ps
module tb_i2s_adc_receiver;
  localparam int DATA_W = 24;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic bclk = 1'b0;
  logic adclrck = 1'b1;
  logic adcdat = 1'b0;
  logic out_ready = 1'b0;
  logic clr_err = 1'b0;
  logic [DATA_W-1:0] left_data, right_data;
  logic out_valid, overrun, short_err;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int h0;
  logic [DATA_W-1:0] cap_l = '0;
  logic [DATA_W-1:0] cap_r = '0;

  i2s_adc_receiver #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .bclk       (bclk),
    .adclrck    (adclrck),
    .adcdat     (adcdat),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .left_data  (left_data),
    .right_data (right_data),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .short_err  (short_err)
  );

  always #5 clk = ~clk;

  // Accepted frames, sampled 1 ns after the falling clk edge
  always @(negedge clk) begin
    #1;
    if (reset_n && out_valid && out_ready) begin
      hs_cnt <= hs_cnt + 1;
      cap_l  <= left_data;
      cap_r  <= right_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bclk period (8 clk): data and word select change on the falling edge
  task automatic send_bit(input logic ws, input logic d, input int hook);
    bclk = 1'b0;
    adclrck = ws;
    adcdat = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
    if (hook == 1) check_eq("latency_before_edge3", 32'(out_valid), 32'd0);
    if (hook == 2) out_ready = 1'b1;
    @(negedge clk);
  endtask

  // Slot bit 0 is the delay slot, bits 1..DATA_W carry the word MSB first
  task automatic send_bits(input logic ws, input logic [DATA_W-1:0] w, input int lo, input int hi, input int hook);
    logic d;
    for (int i = lo; i <= hi; i++) begin
      d = 1'b0;
      if (i >= 1 && i <= DATA_W) d = w[DATA_W-i];
      send_bit(ws, d, (i == hi) ? hook : 0);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    send_bits(1'b0, l, 0, 31, 0);
    send_bits(1'b1, r, 0, 31, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_left", 32'(left_data), 32'h0);
    check_eq("reset_right", 32'(right_data), 32'h0);
    check_eq("reset_valid", 32'(out_valid), 32'd0);
    check_eq("reset_overrun", 32'(overrun), 32'd0);
    check_eq("reset_short", 32'(short_err), 32'd0);
    reset_n = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    send_bits(1'b1, '0, 0, 3, 0);

    // nominal frame with latency probe on the right LSB
    h0 = hs_cnt;
    send_bits(1'b0, 24'hA5A5A5, 0, 31, 0);
    send_bits(1'b1, 24'h3C3C3C, 0, 24, 1);
    check_eq("latency_at_edge3", 32'(out_valid), 32'd1);
    check_eq("nominal_left", 32'(left_data), 32'h00A5A5A5);
    check_eq("nominal_right", 32'(right_data), 32'h003C3C3C);
    send_bits(1'b1, 24'h3C3C3C, 25, 31, 0);
    check_eq("nominal_one_pulse", 32'(hs_cnt - h0), 32'd1);
    check_eq("nominal_overrun", 32'(overrun), 32'd0);
    check_eq("nominal_short", 32'(short_err), 32'd0);

    // backpressure: second frame dropped
    out_ready = 1'b0;
    send_frame(24'h000001, 24'h000002);
    send_frame(24'h000003, 24'h000004);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_left", 32'(left_data), 32'h1);
    check_eq("bp_right", 32'(right_data), 32'h2);
    check_eq("bp_overrun", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check_eq("bp_clr_overrun", 32'(overrun), 32'd0);
    h0 = hs_cnt;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("bp_drain_valid", 32'(out_valid), 32'd0);
    check_eq("bp_drain_count", 32'(hs_cnt - h0), 32'd1);

    // load and accept in the same cycle
    out_ready = 1'b0;
    send_frame(24'h000005, 24'h000006);
    check_eq("sim_hold_valid", 32'(out_valid), 32'd1);
    check_eq("sim_hold_left", 32'(left_data), 32'h5);
    send_bits(1'b0, 24'h000007, 0, 31, 0);
    send_bits(1'b1, 24'h000008, 0, 24, 2);
    check_eq("sim_valid", 32'(out_valid), 32'd1);
    check_eq("sim_left", 32'(left_data), 32'h7);
    check_eq("sim_right", 32'(right_data), 32'h8);
    check_eq("sim_overrun", 32'(overrun), 32'd0);
    send_bits(1'b1, 24'h000008, 25, 31, 0);
    check_eq("sim_drained", 32'(out_valid), 32'd0);

    // short left slot
    h0 = hs_cnt;
    send_bits(1'b0, 24'h0F0F0F, 0, 16, 0);
    send_bits(1'b1, 24'hF0F0F0, 0, 31, 0);
    check_eq("short_flag", 32'(short_err), 32'd1);
    check_eq("short_no_output", 32'(hs_cnt - h0), 32'd0);
    check_eq("short_valid", 32'(out_valid), 32'd0);
    h0 = hs_cnt;
    send_frame(24'h123456, 24'h654321);
    check_eq("short_next_count", 32'(hs_cnt - h0), 32'd1);
    check_eq("short_next_left", 32'(cap_l), 32'h123456);
    check_eq("short_next_right", 32'(cap_r), 32'h654321);

    // reset mid right slot
    send_bits(1'b0, 24'h111111, 0, 31, 0);
    send_bits(1'b1, 24'hABCDEF, 0, 10, 0);
    reset_n = 1'b0;
    #1;
    check_eq("rst_left", 32'(left_data), 32'h0);
    check_eq("rst_right", 32'(right_data), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_short", 32'(short_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    h0 = hs_cnt;
    send_bits(1'b1, 24'hABCDEF, 11, 31, 0);
    check_eq("rst_no_partial", 32'(hs_cnt - h0), 32'd0);
    check_eq("rst_no_partial_valid", 32'(out_valid), 32'd0);
    send_frame(24'h222222, 24'h333333);
    check_eq("rst_first_count", 32'(hs_cnt - h0), 32'd1);
    check_eq("rst_first_left", 32'(cap_l), 32'h222222);
    check_eq("rst_first_right", 32'(cap_r), 32'h333333);

    // en dropped mid left slot
    h0 = hs_cnt;
    send_bits(1'b0, 24'h444444, 0, 10, 0);
    en = 1'b0;
    send_bits(1'b0, 24'h444444, 11, 15, 0);
    en = 1'b1;
    send_bits(1'b0, 24'h444444, 16, 31, 0);
    send_bits(1'b1, 24'h555555, 0, 31, 0);
    check_eq("en_no_output", 32'(hs_cnt - h0), 32'd0);
    send_frame(24'h666666, 24'h777777);
    check_eq("en_next_count", 32'(hs_cnt - h0), 32'd1);
    check_eq("en_next_left", 32'(cap_l), 32'h666666);
    check_eq("en_next_right", 32'(cap_r), 32'h777777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
